fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction-memory request, and owns the IF/ID pipeline register.
- Consumes the stall controls produced by the load-use hazard unit (PCWrite, IF_IDWrite) and the branch flush from ID.
- Tolerates variable-latency instruction memory: one outstanding request at a time, plus a one-entry hold buffer for responses that arrive while IF/ID is stalled.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 137 +++++++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the MIPS instruction-fetch stage: FSM states, the IF/ID
// register layout and the bubble constant.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // IF/ID payload; also the layout of the one-entry hold buffer.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

    function automatic if_id_t bubble();
        if_id_t b;
        b.instr    = NOP_INSTR;
        b.pc_plus4 = 32'h0000_0000;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at
// a time, and owns the IF/ID register plus a one-entry hold buffer.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int               ADDR_W   = 32,
    parameter int               INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               PCWrite,
    input  logic               IF_IDWrite,
    input  logic               IF_Flush,
    input  logic [ADDR_W-1:0]  branch_target,
    fetch_stage_if.master      imem,
    output logic [INSTR_W-1:0] IF_ID_Instr,
    output logic [ADDR_W-1:0]  IF_ID_PCPlus4,
    output logic               IF_ID_Valid
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_HOLD = HOLD;

    logic [1:0]        stateReg,   stateNext;
    logic [ADDR_W-1:0] pcReg,      pcNext;
    logic [ADDR_W-1:0] reqAddrReg, reqAddrNext;
    logic              killReg,    killNext;
    if_id_t            holdReg,    holdNext;
    if_id_t            ifIdReg,    ifIdNext;

    logic [ADDR_W-1:0] pcPlus4;
    logic              accept;
    if_id_t            fetched;

    assign pcPlus4 = pcReg + ADDR_W'(4);
    assign accept  = (stateReg == S_WAIT) && imem.imem_rvalid;

    always_comb begin
        fetched          = bubble();
        fetched.instr    = imem.imem_rdata;
        fetched.pc_plus4 = pcPlus4;
        fetched.valid    = 1'b1;
    end

    always_comb begin
        stateNext   = stateReg;
        pcNext      = pcReg;
        reqAddrNext = reqAddrReg;
        killNext    = killReg;
        holdNext    = holdReg;
        ifIdNext    = ifIdReg;

        if (IF_Flush) begin
            pcNext    = branch_target;
            ifIdNext  = bubble();
            holdNext  = bubble();
            stateNext = S_WAIT;
            // A request still in flight must finish on the bus with its
            // original address; remember that address and drop its data.
            if ((stateReg == S_WAIT) && !accept) begin
                killNext = 1'b1;
                if (!killReg) begin
                    reqAddrNext = pcReg;
                end
            end else begin
                killNext = 1'b0;
            end
        end else begin
            case (stateReg)
                S_IDLE: begin
                    stateNext = S_WAIT;
                end
                S_WAIT: begin
                    if (accept) begin
                        if (killReg) begin
                            killNext = 1'b0;
                            if (IF_IDWrite) begin
                                ifIdNext = bubble();
                            end
                        end else if (IF_IDWrite) begin
                            ifIdNext = fetched;
                            if (PCWrite) begin
                                pcNext = pcPlus4;
                            end
                        end else begin
                            holdNext  = fetched;
                            stateNext = S_HOLD;
                        end
                    end else if (IF_IDWrite) begin
                        ifIdNext = bubble();
                    end
                end
                S_HOLD: begin
                    // PCWrite without IF_IDWrite is treated as a full stall.
                    if (IF_IDWrite) begin
                        ifIdNext  = holdReg;
                        stateNext = S_WAIT;
                        if (PCWrite) begin
                            pcNext = pcPlus4;
                        end
                    end
                end
                default: begin
                    stateNext = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg   <= S_IDLE;
            pcReg      <= RESET_PC;
            reqAddrReg <= '0;
            killReg    <= 1'b0;
            holdReg    <= bubble();
            ifIdReg    <= bubble();
        end else begin
            stateReg   <= stateNext;
            pcReg      <= pcNext;
            reqAddrReg <= reqAddrNext;
            killReg    <= killNext;
            holdReg    <= holdNext;
            ifIdReg    <= ifIdNext;
        end
    end

    assign imem.imem_req  = (stateReg == S_WAIT);
    assign imem.imem_addr = killReg ? reqAddrReg : pcReg;

    assign IF_ID_Instr   = ifIdReg.instr;
    assign IF_ID_PCPlus4 = ifIdReg.pc_plus4;
    assign IF_ID_Valid   = ifIdReg.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal
// expectations, then randomized hazard/flush/latency traffic against a model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        PCWrite = 1'b0;
    logic        IF_IDWrite = 1'b0;
    logic        IF_Flush = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;

    fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) imem ();

    fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCWrite       (PCWrite),
        .IF_IDWrite    (IF_IDWrite),
        .IF_Flush      (IF_Flush),
        .branch_target (branch_target),
        .imem          (imem),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_PCPlus4 (IF_ID_PCPlus4),
        .IF_ID_Valid   (IF_ID_Valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) + 32'h1234_5679;
    endfunction

    // Behavioural model: "what the fetch stage owes the pipeline" per edge.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] killAddr;
        logic [31:0] heldInstr;
        logic [31:0] heldP4;
        logic [31:0] eInstr;
        logic [31:0] eP4;
        logic        req;
        logic        kill;
        logic        started;
        logic        eValid;
    } model_t;

    model_t m;

    function automatic model_t modelStep(input model_t s, input logic rv,
                                         input logic pcw, input logic ifw,
                                         input logic fl, input logic [31:0] tgt);
        model_t n;
        logic acc;
        n = s;
        acc = s.req && rv;
        if (fl) begin
            n.eInstr = 32'h0; n.eP4 = 32'h0; n.eValid = 1'b0;
            if (s.req && !acc) begin
                if (!s.kill) n.killAddr = s.pc;
                n.kill = 1'b1;
            end else begin
                n.kill = 1'b0;
            end
            n.pc  = tgt;
            n.req = 1'b1;
        end else if (!s.started) begin
            n.req = 1'b1;
        end else if (!s.req) begin
            if (ifw) begin
                n.eInstr = s.heldInstr; n.eP4 = s.heldP4; n.eValid = 1'b1;
                if (pcw) n.pc = s.pc + 32'd4;
                n.req = 1'b1;
            end
        end else if (acc) begin
            if (s.kill) begin
                n.kill = 1'b0;
                if (ifw) begin n.eInstr = 32'h0; n.eP4 = 32'h0; n.eValid = 1'b0; end
            end else if (ifw) begin
                n.eInstr = memWord(s.pc); n.eP4 = s.pc + 32'd4; n.eValid = 1'b1;
                if (pcw) n.pc = s.pc + 32'd4;
            end else begin
                n.heldInstr = memWord(s.pc); n.heldP4 = s.pc + 32'd4;
                n.req = 1'b0;
            end
        end else if (ifw) begin
            n.eInstr = 32'h0; n.eP4 = 32'h0; n.eValid = 1'b0;
        end
        n.started = 1'b1;
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else m <= modelStep(m, imem.imem_rvalid, PCWrite, IF_IDWrite, IF_Flush, branch_target);
    end

    // Per-cycle compare of every output against the model.
    always @(negedge clk) begin
        chk("cyc_req", {31'h0, imem.imem_req}, {31'h0, m.req});
        if (m.req) chk("cyc_addr", imem.imem_addr, m.kill ? m.killAddr : m.pc);
        chk("cyc_instr", IF_ID_Instr, m.eInstr);
        chk("cyc_pcplus4", IF_ID_PCPlus4, m.eP4);
        chk("cyc_valid", {31'h0, IF_ID_Valid}, {31'h0, m.eValid});
    end

    // Memory: each request answers after curLat cycles (1 = same cycle).
    int waitCnt = 0;
    int curLat = 1;
    int fixedLat = 1;

    task automatic step(input logic pcw, input logic ifw, input logic fl, input logic [31:0] tgt);
        @(negedge clk);
        PCWrite = pcw;
        IF_IDWrite = ifw;
        IF_Flush = fl;
        branch_target = tgt;
        if (imem.imem_req) begin
            if (waitCnt >= curLat - 1) begin
                imem.imem_rvalid = 1'b1;
                imem.imem_rdata = memWord(imem.imem_addr);
            end else begin
                imem.imem_rvalid = 1'b0;
                imem.imem_rdata = $urandom;
            end
        end else begin
            imem.imem_rvalid = 1'($urandom_range(0, 1));
            imem.imem_rdata = $urandom;
            waitCnt = 0;
        end
        if (imem.imem_req && imem.imem_rvalid) begin
            $display("txn t=%0t addr=%h rdata=%h stall=%0d flush=%0d", $time,
                     imem.imem_addr, imem.imem_rdata, !ifw, fl);
            waitCnt = 0;
            curLat = (fixedLat > 0) ? fixedLat : int'($urandom_range(1, 4));
        end else if (imem.imem_req) begin
            waitCnt++;
        end
    endtask

    task automatic chkIfId(input string name, input logic v, input logic [31:0] p4, input logic [31:0] ins);
        chk({name, "_valid"}, {31'h0, IF_ID_Valid}, {31'h0, v});
        chk({name, "_pcplus4"}, IF_ID_PCPlus4, p4);
        chk({name, "_instr"}, IF_ID_Instr, ins);
    endtask

    initial begin
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata = 32'h0;

        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        chk("reset_req", {31'h0, imem.imem_req}, 32'h0);
        chkIfId("reset", 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // Back-to-back same-cycle responses.
        step(1, 1, 0, 32'h0);
        chk("b2b_req", {31'h0, imem.imem_req}, 32'h1);
        chk("b2b_addr0", imem.imem_addr, 32'h0);
        step(1, 1, 0, 32'h0);
        chk("b2b_addr4", imem.imem_addr, 32'h4);
        chkIfId("b2b_0", 1'b1, 32'h4, memWord(32'h0));
        fixedLat = 3;
        step(1, 1, 0, 32'h0);
        chk("b2b_addr8", imem.imem_addr, 32'h8);
        chkIfId("b2b_1", 1'b1, 32'h8, memWord(32'h4));

        // Three-cycle latency: two bubbles between accepts.
        step(1, 1, 0, 32'h0);
        chkIfId("lat_a", 1'b1, 32'hC, memWord(32'h8));
        step(1, 1, 0, 32'h0);
        chkIfId("lat_bub1", 1'b0, 32'h0, 32'h0);
        step(1, 1, 0, 32'h0);
        chkIfId("lat_bub2", 1'b0, 32'h0, 32'h0);
        step(1, 1, 0, 32'h0);
        chkIfId("lat_b", 1'b1, 32'h10, memWord(32'hC));
        chk("lat_addr", imem.imem_addr, 32'h10);

        // Stall while the 0x10 response arrives: HOLD, then release.
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        step(0, 0, 0, 32'h0);
        chk("hold_req", {31'h0, imem.imem_req}, 32'h0);
        step(1, 1, 0, 32'h0);
        chk("hold_req2", {31'h0, imem.imem_req}, 32'h0);
        chkIfId("hold_held", 1'b0, 32'h0, 32'h0);

        // Release: held word enters IF/ID; flush the new 0x14 request.
        step(1, 1, 1, 32'h40);
        chk("rel_addr", imem.imem_addr, 32'h14);
        chkIfId("rel", 1'b1, 32'h14, memWord(32'h10));
        step(1, 1, 0, 32'h0);
        chk("kill_addr", imem.imem_addr, 32'h14);
        chkIfId("kill_bub", 1'b0, 32'h0, 32'h0);
        fixedLat = 1;
        step(1, 1, 0, 32'h0);
        chk("kill_addr2", imem.imem_addr, 32'h14);
        step(1, 1, 0, 32'h0);
        chk("redir_addr", imem.imem_addr, 32'h40);
        chkIfId("redir_bub", 1'b0, 32'h0, 32'h0);

        // Flush coincident with accept, with stall asserted.
        step(0, 0, 1, 32'h100);
        chkIfId("redir", 1'b1, 32'h44, memWord(32'h40));
        step(1, 1, 1, 32'hFFFF_FFFC);
        chk("fa_addr", imem.imem_addr, 32'h100);
        chkIfId("fa_bub", 1'b0, 32'h0, 32'h0);

        // PC wrap-around.
        step(1, 1, 0, 32'h0);
        chk("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 32'h0);
        chkIfId("wrap", 1'b1, 32'h0, memWord(32'hFFFF_FFFC));
        chk("wrap_next", imem.imem_addr, 32'h0);

        // Asynchronous reset while in HOLD.
        step(0, 0, 0, 32'h0);
        chk("rhold_req", {31'h0, imem.imem_req}, 32'h0);
        #3 rst_n = 1'b0;
        #1;
        chk("areset_req", {31'h0, imem.imem_req}, 32'h0);
        chkIfId("areset", 1'b0, 32'h0, 32'h0);
        step(1, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        rst_n = 1'b1;

        // Randomized traffic.
        fixedLat = 0;
        for (int i = 0; i < 1500; i++) begin
            int r;
            logic [31:0] tgt;
            r = int'($urandom_range(0, 15));
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF8;
            if (r == 0) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, tgt);
            else if (r <= 3) step(1'b0, 1'b0, 1'b0, tgt);
            else if (r == 4) step(1'b1, 1'b0, 1'b0, tgt);
            else step(1'b1, 1'b1, 1'b0, tgt);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
